jpeg_dht_prog: RTL and testbench
================================

Name: jpeg_dht_prog

Overview:
Programmable Huffman decode-table block for the baseline JPEG decoder. It parses DHT segment payload bytes from the config stream and builds canonical-code tables: per-length min code, count and value pointer, plus a symbol RAM. It serves pipelined code lookups to the entropy decoder.
It generalises the fixed-table lookup in three ways: a parametrised table count, writable tables, and invalid-code reporting.

Parameters:
NUM_TABLES, 4, number of tables (even, >=2); table index = {Th, Tc}, so index 0 = Y DC, 1 = Y AC, 2 = Cx DC, 3 = Cx AC
VALUE_DEPTH, 256, symbol RAM entries per table (<=256)
TABLE_ID_W, $clog2(NUM_TABLES), derived localparam, not overridable

Ports:
clk_i  in  1  clock
rst_i  in  1  reset
cfg_valid_i  in  1  config byte valid
cfg_data_i  in  8  DHT payload byte (the 2-byte length field is already stripped)
cfg_last_i  in  1  last byte of segment
cfg_accept_o  out  1  config byte accepted
lookup_req_i  in  1  lookup request
lookup_table_i  in  TABLE_ID_W  table select
lookup_input_i  in  16  next bitstream bits, MSB = first bit
lookup_valid_o  out  1  lookup result valid
lookup_width_o  out  5  code length 1..16; 0 = no match
lookup_value_o  out  8  decoded symbol
table_valid_o  out  NUM_TABLES  per-table loaded flag
cfg_error_o  out  1  sticky malformed-segment flag

Behaviour:
- Clock and reset: single clock clk_i; rst_i is synchronous, active-high.
- Reset values: all outputs 0 except cfg_accept_o = 1; count arrays cleared; FSM in ST_HDR.
- Config handshake: a byte transfers when cfg_valid_i && cfg_accept_o. cfg_accept_o is held at 1, giving one byte per cycle in every state.
- ST_HDR (header byte): Tc = data[7:4], Th = data[3:0].
  - Error if Tc>1 or {Th,Tc} >= NUM_TABLES.
  - Otherwise latch the index, clear table_valid_o[idx], reset code=0 and ptr=0, go to ST_CNT.
- ST_CNT (16 count bytes, L = 1..16), on each byte:
  - mincode[L] = code; cnt[L] = byte; valptr[L] = ptr
  - code = (code + byte) << 1; ptr += byte (9-bit)
  - Error if ptr > VALUE_DEPTH, or if any code exceeds L bits (code + byte > 2^L).
  - After L = 16: if ptr == 0, set table_valid_o[idx] and go to ST_HDR; otherwise go to ST_VAL.
- ST_VAL (ptr symbol bytes): write each byte to RAM[idx][wr_ptr]. After the last write, set table_valid_o[idx] and go to ST_HDR.
- Segment boundaries:
  - cfg_last_i on the final byte of a table: go to ST_HDR.
  - cfg_last_i with a table incomplete: error, table left invalid.
  - Bytes after a non-last table completes are parsed as the next header.
- ST_ERR: set cfg_error_o (sticky until reset). Drop bytes until cfg_last_i is accepted, then go to ST_HDR. Valid flags of other tables are untouched.
- Lookup pipeline, fully pipelined, 1 request per cycle, latency 2: lookup_valid_o rises 2 cycles after lookup_req_i.
- Lookup stage 1:
  - For each L = 1..16, cand = input[15:16-L]; hit[L] = cnt[L] != 0 && (cand - mincode[L]) < cnt[L].
  - Take the smallest hit L; idx = valptr[L] + cand - mincode[L].
  - Register L, table, and a miss flag; issue the RAM read.
- Lookup stage 2: output width = L and value = RAM data.
- Miss handling: on no hit, or table_valid_o[sel] = 0, output width 0 and value 0, with lookup_valid_o still asserted.
- Lookup against a table being written: result is undefined but still flagged valid. The decoder must not do this.
- Reset mid-load or mid-lookup: the pipeline is flushed (lookup_valid_o = 0 next cycle) and all tables become invalid.

Decomposition:
- Package jpeg_dht_pkg: FSM state encodings (ST_HDR, ST_CNT, ST_VAL, ST_ERR), DHT_MAX_LEN = 16, table-class constants (CLASS_DC = 0, CLASS_AC = 1).
- Sub-module jpeg_dht_value_ram: 1-write/1-read synchronous RAM, NUM_TABLES*VALUE_DEPTH x 8, read latency 1.

Test Plan:
- Load std luma DC into table 0 (header 00; counts 00 01 05 01 01 01 01 01 01 00 00 00 00 00 00 00; values 00..0B) -> table_valid_o = 4'b0001 and cfg_error_o = 0.
- Lookups on table 0 after that load, with a 2-cycle latency check:
  - 16'h0000 -> width 2, value 00
  - 16'h4000 -> width 3, value 01
  - 16'hFF00 -> width 9, value 0B
  - 16'hFFFF -> width 0, value 00
- One segment carrying Y DC (header 00) then std Y AC (header 10, 162 values), cfg_last_i on the final byte only -> table_valid_o = 4'b0011.
- Header 8'h25 with cfg_last_i on byte 20 -> cfg_error_o = 1, table_valid_o unchanged. A following valid segment then loads table 2 correctly.
- Lookups every cycle alternating tables 0 and 1 for 20 cycles -> lookup_valid_o high 20 consecutive cycles, results in order, matching the golden model.
- Assert rst_i during ST_VAL -> next cycle table_valid_o = 0, cfg_error_o = 0, lookup_valid_o = 0. A reload then succeeds.

Source files
------------

// File: rtl/jpeg_dht_pkg.sv
// Shared definitions for the programmable JPEG Huffman table block:
// parser states, code-length bound, table classes and the code-space check.
package jpeg_dht_pkg;

    typedef enum logic [1:0] {
        ST_HDR = 2'd0,
        ST_CNT = 2'd1,
        ST_VAL = 2'd2,
        ST_ERR = 2'd3
    } dht_state_e;

    localparam int DHT_MAX_LEN = 16;

    localparam logic [3:0] CLASS_DC = 4'd0;
    localparam logic [3:0] CLASS_AC = 4'd1;

    // True when the codes of length len would not fit in len bits.
    function automatic logic code_overflow(input logic [17:0] code,
                                           input logic [7:0]  count,
                                           input logic [4:0]  len);
        return (code + {10'd0, count}) > (18'd1 << len);
    endfunction

endpackage

// File: rtl/jpeg_dht_prog_if.sv
// Config-stream and lookup bus of jpeg_dht_prog; the slave modport is the table block.
interface jpeg_dht_prog_if #(
    parameter int NUM_TABLES = 4
);
    localparam int TABLE_ID_W = $clog2(NUM_TABLES);

    logic                  cfg_valid_i;
    logic [7:0]            cfg_data_i;
    logic                  cfg_last_i;
    logic                  cfg_accept_o;
    logic                  lookup_req_i;
    logic [TABLE_ID_W-1:0] lookup_table_i;
    logic [15:0]           lookup_input_i;
    logic                  lookup_valid_o;
    logic [4:0]            lookup_width_o;
    logic [7:0]            lookup_value_o;
    logic [NUM_TABLES-1:0] table_valid_o;
    logic                  cfg_error_o;

    modport master (
        output cfg_valid_i, cfg_data_i, cfg_last_i,
        output lookup_req_i, lookup_table_i, lookup_input_i,
        input  cfg_accept_o, lookup_valid_o, lookup_width_o, lookup_value_o,
        input  table_valid_o, cfg_error_o
    );

    modport slave (
        input  cfg_valid_i, cfg_data_i, cfg_last_i,
        input  lookup_req_i, lookup_table_i, lookup_input_i,
        output cfg_accept_o, lookup_valid_o, lookup_width_o, lookup_value_o,
        output table_valid_o, cfg_error_o
    );

endinterface

// File: rtl/jpeg_dht_value_ram.sv
// Symbol store for all tables: one write port, one read port, registered read data.
module jpeg_dht_value_ram #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [7:0]        wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [7:0]        rdata_o
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/jpeg_dht_prog.sv
// DHT payload parser building canonical Huffman tables, plus a two-stage
// code lookup (length match, then symbol RAM read) for the entropy decoder.
module jpeg_dht_prog #(
    parameter int NUM_TABLES  = 4,
    parameter int VALUE_DEPTH = 256
) (
    input  logic           clk_i,
    input  logic           rst_i,
    jpeg_dht_prog_if.slave bus
);
    import jpeg_dht_pkg::*;

    localparam int TABLE_ID_W = $clog2(NUM_TABLES);
    localparam int ADDR_W     = $clog2(NUM_TABLES * VALUE_DEPTH);
    localparam logic [8:0]        VD_L    = 9'(VALUE_DEPTH);
    localparam logic [ADDR_W-1:0] DEPTH_L = ADDR_W'(VALUE_DEPTH);
    localparam logic [5:0]        NUMT_L  = 6'(NUM_TABLES);

    dht_state_e            state_q, state_d;
    logic [TABLE_ID_W-1:0] idx_q, idx_d;
    logic [3:0]            len_q, len_d;
    logic [17:0]           code_q, code_d;
    logic [8:0]            ptr_q, ptr_d;
    logic [8:0]            wr_ptr_q, wr_ptr_d;
    logic [NUM_TABLES-1:0] table_valid_q, table_valid_d;
    logic                  err_q, err_d;
    logic                  accept_q;

    logic [15:0] mincode_q [NUM_TABLES][DHT_MAX_LEN];
    logic [7:0]  cnt_q     [NUM_TABLES][DHT_MAX_LEN];
    logic [8:0]  valptr_q  [NUM_TABLES][DHT_MAX_LEN];

    logic                  xfer_s, last_s, cnt_wr_s, ram_we_s, hdr_bad_s, cnt_err_s;
    logic [3:0]            hdr_tc_s, hdr_th_s;
    logic [TABLE_ID_W-1:0] hdr_idx_s;
    logic [17:0]           code_sum_s;
    logic [8:0]            ptr_sum_s;
    logic [ADDR_W-1:0]     wr_addr_s, rd_addr_s;

    assign xfer_s     = bus.cfg_valid_i & accept_q;
    assign last_s     = bus.cfg_last_i;
    assign hdr_tc_s   = bus.cfg_data_i[7:4];
    assign hdr_th_s   = bus.cfg_data_i[3:0];
    assign hdr_idx_s  = TABLE_ID_W'({hdr_th_s, hdr_tc_s[0]});
    assign hdr_bad_s  = (hdr_tc_s > CLASS_AC) || ({1'b0, hdr_th_s, hdr_tc_s[0]} >= NUMT_L);
    assign code_sum_s = code_q + {10'd0, bus.cfg_data_i};
    assign ptr_sum_s  = ptr_q + {1'b0, bus.cfg_data_i};
    assign cnt_err_s  = code_overflow(code_q, bus.cfg_data_i, {1'b0, len_q} + 5'd1) ||
                        (ptr_sum_s > VD_L);
    assign wr_addr_s  = ADDR_W'(idx_q) * DEPTH_L + ADDR_W'(wr_ptr_q);

    // Parser state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_HDR;
            idx_q         <= '0;
            len_q         <= 4'd0;
            code_q        <= 18'd0;
            ptr_q         <= 9'd0;
            wr_ptr_q      <= 9'd0;
            table_valid_q <= '0;
            err_q         <= 1'b0;
            accept_q      <= 1'b1;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            len_q         <= len_d;
            code_q        <= code_d;
            ptr_q         <= ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            table_valid_q <= table_valid_d;
            err_q         <= err_d;
            accept_q      <= 1'b1;
        end
    end

    // Parser next state; any error ending on a last byte resynchronises straight to ST_HDR
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        len_d         = len_q;
        code_d        = code_q;
        ptr_d         = ptr_q;
        wr_ptr_d      = wr_ptr_q;
        table_valid_d = table_valid_q;
        err_d         = err_q;
        cnt_wr_s      = 1'b0;
        ram_we_s      = 1'b0;
        if (xfer_s) begin
            case (state_q)
                ST_HDR: begin
                    if (hdr_bad_s) begin
                        err_d   = 1'b1;
                        state_d = last_s ? ST_HDR : ST_ERR;
                    end else begin
                        table_valid_d[hdr_idx_s] = 1'b0;
                        idx_d  = hdr_idx_s;
                        len_d  = 4'd0;
                        code_d = 18'd0;
                        ptr_d  = 9'd0;
                        if (last_s) begin
                            err_d   = 1'b1;
                            state_d = ST_HDR;
                        end else begin
                            state_d = ST_CNT;
                        end
                    end
                end
                ST_CNT: begin
                    cnt_wr_s = 1'b1;
                    code_d   = code_sum_s << 1;
                    ptr_d    = ptr_sum_s;
                    len_d    = len_q + 4'd1;
                    wr_ptr_d = 9'd0;
                    if (cnt_err_s) begin
                        err_d   = 1'b1;
                        state_d = last_s ? ST_HDR : ST_ERR;
                    end else if (len_q == 4'd15 && ptr_sum_s == 9'd0) begin
                        table_valid_d[idx_q] = 1'b1;
                        state_d = ST_HDR;
                    end else if (last_s) begin
                        err_d   = 1'b1;
                        state_d = ST_HDR;
                    end else if (len_q == 4'd15) begin
                        state_d = ST_VAL;
                    end else begin
                        state_d = ST_CNT;
                    end
                end
                ST_VAL: begin
                    ram_we_s = 1'b1;
                    wr_ptr_d = wr_ptr_q + 9'd1;
                    if (wr_ptr_q == ptr_q - 9'd1) begin
                        table_valid_d[idx_q] = 1'b1;
                        state_d = ST_HDR;
                    end else if (last_s) begin
                        err_d   = 1'b1;
                        state_d = ST_HDR;
                    end else begin
                        state_d = ST_VAL;
                    end
                end
                ST_ERR: begin
                    state_d = last_s ? ST_HDR : ST_ERR;
                end
                default: begin
                    state_d = ST_HDR;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Per-length canonical code parameters, captured while counts stream in
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int t = 0; t < NUM_TABLES; t++) begin
                for (int l = 0; l < DHT_MAX_LEN; l++) begin
                    mincode_q[t][l] <= 16'd0;
                    cnt_q[t][l]     <= 8'd0;
                    valptr_q[t][l]  <= 9'd0;
                end
            end
        end else if (cnt_wr_s) begin
            mincode_q[idx_q][len_q] <= code_q[15:0];
            cnt_q[idx_q][len_q]     <= bus.cfg_data_i;
            valptr_q[idx_q][len_q]  <= ptr_q;
        end
    end

    logic        hit_s;
    logic [4:0]  hit_len_s;
    logic [8:0]  rd_off_s;
    logic [16:0] cand_v, diff_v;
    logic [7:0]  ram_rdata_s;

    // Stage 1 match: scanning from long to short leaves the shortest hit
    always_comb begin
        hit_s     = 1'b0;
        hit_len_s = 5'd0;
        rd_off_s  = 9'd0;
        cand_v    = 17'd0;
        diff_v    = 17'd0;
        for (int l = DHT_MAX_LEN; l >= 1; l--) begin
            cand_v = 17'({1'b0, bus.lookup_input_i} >> (DHT_MAX_LEN - l));
            diff_v = cand_v - {1'b0, mincode_q[bus.lookup_table_i][l-1]};
            if ((cnt_q[bus.lookup_table_i][l-1] != 8'd0) &&
                (cand_v >= {1'b0, mincode_q[bus.lookup_table_i][l-1]}) &&
                (diff_v < {9'd0, cnt_q[bus.lookup_table_i][l-1]})) begin
                hit_s     = 1'b1;
                hit_len_s = 5'(l);
                rd_off_s  = valptr_q[bus.lookup_table_i][l-1] + diff_v[8:0];
            end else begin
                hit_s = hit_s;
            end
        end
    end

    assign rd_addr_s = ADDR_W'(bus.lookup_table_i) * DEPTH_L + ADDR_W'(rd_off_s);

    jpeg_dht_value_ram #(
        .DEPTH  (NUM_TABLES * VALUE_DEPTH),
        .ADDR_W (ADDR_W)
    ) u_value_ram (
        .clk_i   (clk_i),
        .we_i    (ram_we_s),
        .waddr_i (wr_addr_s),
        .wdata_i (bus.cfg_data_i),
        .re_i    (bus.lookup_req_i),
        .raddr_i (rd_addr_s),
        .rdata_o (ram_rdata_s)
    );

    logic       s1_valid_q, s1_miss_q;
    logic [4:0] s1_width_q;
    logic       out_valid_q;
    logic [4:0] out_width_q;
    logic [7:0] out_value_q;

    // Lookup pipeline registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q  <= 1'b0;
            s1_miss_q   <= 1'b1;
            s1_width_q  <= 5'd0;
            out_valid_q <= 1'b0;
            out_width_q <= 5'd0;
            out_value_q <= 8'd0;
        end else begin
            s1_valid_q  <= bus.lookup_req_i;
            s1_miss_q   <= ~(hit_s & table_valid_q[bus.lookup_table_i]);
            s1_width_q  <= hit_len_s;
            out_valid_q <= s1_valid_q;
            out_width_q <= s1_miss_q ? 5'd0 : s1_width_q;
            out_value_q <= s1_miss_q ? 8'd0 : ram_rdata_s;
        end
    end

    assign bus.cfg_accept_o   = accept_q;
    assign bus.cfg_error_o    = err_q;
    assign bus.table_valid_o  = table_valid_q;
    assign bus.lookup_valid_o = out_valid_q;
    assign bus.lookup_width_o = out_width_q;
    assign bus.lookup_value_o = out_value_q;

endmodule

// File: tb/tb_jpeg_dht_prog.sv
// Bench for jpeg_dht_prog: loads standard JPEG tables and checks lookups against
// a canonical-code enumeration model plus hand-derived results.
module tb_jpeg_dht_prog;

    localparam int NT = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    jpeg_dht_prog_if #(.NUM_TABLES(NT)) bus ();

    jpeg_dht_prog #(.NUM_TABLES(NT), .VALUE_DEPTH(256)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // 0 = luma DC, 1 = luma AC, 2 = chroma DC
    logic [7:0] lib_cnt [3][16] = '{
        '{8'd0, 8'd1, 8'd5, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0},
        '{8'd0, 8'd2, 8'd1, 8'd3, 8'd3, 8'd2, 8'd4, 8'd3, 8'd5, 8'd5, 8'd4, 8'd4, 8'd0, 8'd0, 8'd1, 8'h7d},
        '{8'd0, 8'd3, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}
    };

    logic [7:0] ac_vals [162] = '{
        8'h01, 8'h02, 8'h03, 8'h00, 8'h04, 8'h11, 8'h05, 8'h12, 8'h21, 8'h31, 8'h41, 8'h06, 8'h13, 8'h51, 8'h61, 8'h07,
        8'h22, 8'h71, 8'h14, 8'h32, 8'h81, 8'h91, 8'ha1, 8'h08, 8'h23, 8'h42, 8'hb1, 8'hc1, 8'h15, 8'h52, 8'hd1, 8'hf0,
        8'h24, 8'h33, 8'h62, 8'h72, 8'h82, 8'h09, 8'h0a, 8'h16, 8'h17, 8'h18, 8'h19, 8'h1a, 8'h25, 8'h26, 8'h27, 8'h28,
        8'h29, 8'h2a, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h3a, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h49,
        8'h4a, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57, 8'h58, 8'h59, 8'h5a, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h69,
        8'h6a, 8'h73, 8'h74, 8'h75, 8'h76, 8'h77, 8'h78, 8'h79, 8'h7a, 8'h83, 8'h84, 8'h85, 8'h86, 8'h87, 8'h88, 8'h89,
        8'h8a, 8'h92, 8'h93, 8'h94, 8'h95, 8'h96, 8'h97, 8'h98, 8'h99, 8'h9a, 8'ha2, 8'ha3, 8'ha4, 8'ha5, 8'ha6, 8'ha7,
        8'ha8, 8'ha9, 8'haa, 8'hb2, 8'hb3, 8'hb4, 8'hb5, 8'hb6, 8'hb7, 8'hb8, 8'hb9, 8'hba, 8'hc2, 8'hc3, 8'hc4, 8'hc5,
        8'hc6, 8'hc7, 8'hc8, 8'hc9, 8'hca, 8'hd2, 8'hd3, 8'hd4, 8'hd5, 8'hd6, 8'hd7, 8'hd8, 8'hd9, 8'hda, 8'he1, 8'he2,
        8'he3, 8'he4, 8'he5, 8'he6, 8'he7, 8'he8, 8'he9, 8'hea, 8'hf1, 8'hf2, 8'hf3, 8'hf4, 8'hf5, 8'hf6, 8'hf7, 8'hf8,
        8'hf9, 8'hfa
    };

    function automatic int lib_total(input int w);
        int s = 0;
        for (int l = 0; l < 16; l++) s += int'(lib_cnt[w][l]);
        return s;
    endfunction

    function automatic logic [7:0] lib_val(input int w, input int i);
        if (w == 1) return ac_vals[i];
        return 8'(i);
    endfunction

    // Model: tables as count lists and symbol lists, decoded by enumerating canonical codes
    bit         mdl_valid [NT];
    logic [7:0] mdl_cnt   [NT][16];
    logic [7:0] mdl_sym   [NT][256];

    task automatic mdl_load(input int t, input int w);
        for (int l = 0; l < 16; l++) mdl_cnt[t][l] = lib_cnt[w][l];
        for (int i = 0; i < lib_total(w); i++) mdl_sym[t][i] = lib_val(w, i);
        mdl_valid[t] = 1'b1;
    endtask

    function automatic logic [12:0] mdl_lookup(input int t, input logic [15:0] bits);
        int code = 0;
        int k = 0;
        logic [12:0] r = 13'd0;
        if (!mdl_valid[t]) return 13'd0;
        for (int l = 1; l <= 16; l++) begin
            for (int i = 0; i < int'(mdl_cnt[t][l-1]); i++) begin
                if (r == 13'd0 && int'(bits >> (16 - l)) == code) r = {5'(l), mdl_sym[t][k]};
                code++;
                k++;
            end
            code = code << 1;
        end
        return r;
    endfunction

    logic [7:0] sq [$];

    task automatic push_tab(input logic [7:0] hdr, input int w);
        sq.push_back(hdr);
        for (int l = 0; l < 16; l++) sq.push_back(lib_cnt[w][l]);
        for (int i = 0; i < lib_total(w); i++) sq.push_back(lib_val(w, i));
    endtask

    task automatic send_stream();
        for (int i = 0; i < sq.size(); i++) begin
            bus.cfg_valid_i = 1'b1;
            bus.cfg_data_i  = sq[i];
            bus.cfg_last_i  = (i == sq.size() - 1);
            @(negedge clk);
        end
        bus.cfg_valid_i = 1'b0;
        bus.cfg_last_i  = 1'b0;
        sq.delete();
    endtask

    task automatic lookup_one(input string name, input logic [1:0] t, input logic [15:0] in,
                              input logic [4:0] ew, input logic [7:0] ev);
        bus.lookup_req_i   = 1'b1;
        bus.lookup_table_i = t;
        bus.lookup_input_i = in;
        @(negedge clk);
        bus.lookup_req_i = 1'b0;
        chk({name, "_early"}, 32'(bus.lookup_valid_o), 32'd0);
        @(negedge clk);
        chk({name, "_valid"}, 32'(bus.lookup_valid_o), 32'd1);
        chk({name, "_width"}, 32'(bus.lookup_width_o), 32'(ew));
        chk({name, "_value"}, 32'(bus.lookup_value_o), 32'(ev));
        @(negedge clk);
    endtask

    // Expected-result pipe: what each request must produce two cycles later
    logic        p0v = 1'b0, p1v = 1'b0;
    logic [12:0] p0r = 13'd0, p1r = 13'd0;
    bit          chk_en = 1'b0;
    int          run = 0, maxrun = 0;

    always @(posedge clk) begin
        if (rst) begin
            p0v <= 1'b0;
            p1v <= 1'b0;
        end else begin
            p1v <= p0v;
            p1r <= p0r;
            p0v <= bus.lookup_req_i;
            p0r <= mdl_lookup(int'(bus.lookup_table_i), bus.lookup_input_i);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("pipe_valid", 32'(bus.lookup_valid_o), 32'(p1v));
            if (p1v) begin
                chk("pipe_width", 32'(bus.lookup_width_o), 32'(p1r[12:8]));
                chk("pipe_value", 32'(bus.lookup_value_o), 32'(p1r[7:0]));
            end
            if (bus.lookup_valid_o === 1'b1) run++;
            else run = 0;
            if (run > maxrun) maxrun = run;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    logic [15:0] bvec [10] = '{16'h0000, 16'h4000, 16'h8000, 16'hA000, 16'hC000,
                               16'hE000, 16'hF000, 16'hFF00, 16'hFFC0, 16'hFFFF};

    initial begin
        rst                = 1'b1;
        bus.cfg_valid_i    = 1'b0;
        bus.cfg_data_i     = 8'd0;
        bus.cfg_last_i     = 1'b0;
        bus.lookup_req_i   = 1'b0;
        bus.lookup_table_i = 2'd0;
        bus.lookup_input_i = 16'd0;
        repeat (2) @(negedge clk);
        chk("rst_accept", 32'(bus.cfg_accept_o), 32'd1);
        chk("rst_tvalid", 32'(bus.table_valid_o), 32'd0);
        chk("rst_error", 32'(bus.cfg_error_o), 32'd0);
        chk("rst_lvalid", 32'(bus.lookup_valid_o), 32'd0);
        rst    = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);

        push_tab(8'h00, 0);
        send_stream();
        mdl_load(0, 0);
        chk("dc_tvalid", 32'(bus.table_valid_o), 32'h1);
        chk("dc_error", 32'(bus.cfg_error_o), 32'd0);
        chk("dc_accept", 32'(bus.cfg_accept_o), 32'd1);
        lookup_one("dc_0000", 2'd0, 16'h0000, 5'd2, 8'h00);
        lookup_one("dc_4000", 2'd0, 16'h4000, 5'd3, 8'h01);
        lookup_one("dc_ff00", 2'd0, 16'hFF00, 5'd9, 8'h0B);
        lookup_one("dc_ffff", 2'd0, 16'hFFFF, 5'd0, 8'h00);

        push_tab(8'h00, 0);
        push_tab(8'h10, 1);
        send_stream();
        mdl_load(1, 1);
        chk("seg2_tvalid", 32'(bus.table_valid_o), 32'h3);
        lookup_one("ac_0000", 2'd1, 16'h0000, 5'd2, 8'h01);
        lookup_one("ac_eob", 2'd1, 16'hA000, 5'd4, 8'h00);
        lookup_one("ac_ffff", 2'd1, 16'hFFFF, 5'd0, 8'h00);
        lookup_one("unloaded", 2'd3, 16'h0000, 5'd0, 8'h00);

        sq.push_back(8'h25);
        for (int i = 1; i < 20; i++) sq.push_back(8'(i));
        send_stream();
        chk("bad_error", 32'(bus.cfg_error_o), 32'd1);
        chk("bad_tvalid", 32'(bus.table_valid_o), 32'h3);
        push_tab(8'h01, 2);
        send_stream();
        mdl_load(2, 2);
        chk("cdc_tvalid", 32'(bus.table_valid_o), 32'h7);
        chk("cdc_error", 32'(bus.cfg_error_o), 32'd1);
        lookup_one("cdc_c000", 2'd2, 16'hC000, 5'd3, 8'h03);

        maxrun = 0;
        for (int i = 0; i < 20; i++) begin
            bus.lookup_req_i   = 1'b1;
            bus.lookup_table_i = 2'(i % 2);
            bus.lookup_input_i = bvec[(i / 2) % 10];
            @(negedge clk);
        end
        bus.lookup_req_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("burst_run", 32'(maxrun), 32'd20);

        push_tab(8'h11, 1);
        for (int i = 0; i < 22; i++) begin
            bus.cfg_valid_i = 1'b1;
            bus.cfg_data_i  = sq[i];
            bus.cfg_last_i  = 1'b0;
            @(negedge clk);
        end
        sq.delete();
        bus.cfg_valid_i    = 1'b0;
        bus.lookup_req_i   = 1'b1;
        bus.lookup_table_i = 2'd0;
        bus.lookup_input_i = 16'h0000;
        @(negedge clk);
        bus.lookup_req_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_tvalid", 32'(bus.table_valid_o), 32'd0);
        chk("mrst_error", 32'(bus.cfg_error_o), 32'd0);
        chk("mrst_lvalid", 32'(bus.lookup_valid_o), 32'd0);
        rst = 1'b0;
        for (int t = 0; t < NT; t++) mdl_valid[t] = 1'b0;
        @(negedge clk);
        lookup_one("mrst_miss", 2'd0, 16'h0000, 5'd0, 8'h00);

        push_tab(8'h00, 0);
        send_stream();
        mdl_load(0, 0);
        chk("reload_tvalid", 32'(bus.table_valid_o), 32'h1);
        chk("reload_error", 32'(bus.cfg_error_o), 32'd0);
        lookup_one("reload_ff00", 2'd0, 16'hFF00, 5'd9, 8'h0B);
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
